intr_ack_sequencer: RTL
=======================

Name: intr_ack_sequencer

Overview:
- Sequences the 8259-style interrupt acknowledge cycle.
- Takes the masked request vector from the IRR stage and asserts INT to the CPU.
- Runs the two-pulse INTA handshake, maintains the In-Service Register (ISR) and supplies the 8-bit vector.
- Processes EOI commands, including priority rotation.
- Sits between the IRR/priority stage and the data-bus buffer.

Parameters:
LOW_PRIO_RST, 3'd7, reset value of the lowest-priority pointer (7 gives IR0 highest priority).
INTA_SYNC, 0, if 1, a 2-flop synchronizer is inserted on inta, adding 2 cycles to edge detection.

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
irr  in  8  masked, pending requests (bit n = IRn)
inta  in  1  CPU acknowledge, active-high level; one pulse = rise then fall
vector_base  in  5  upper vector bits (ICW2 T7..T3)
auto_eoi  in  1  1 = ISR bit cleared automatically at end of second INTA
eoi  in  1  one-cycle EOI command strobe
eoi_specific  in  1  qualifies eoi: 1 = specific, 0 = non-specific
eoi_level  in  3  IR level for specific EOI
eoi_rotate  in  1  qualifies eoi: rotate priority on EOI
int_req  out  1  INT to CPU
isr  out  8  In-Service Register
clr_irr  out  8  one-cycle pulse clearing the acknowledged IRR bit
data_out  out  8  vector / poll word
data_valid  out  1  one-cycle strobe, data_out valid

Behaviour:
- Reset values: int_req=0, isr=0, clr_irr=0, data_out=0, data_valid=0, low_prio=LOW_PRIO_RST, state=IDLE, inta_d=0.
- Reset takes effect immediately at any point, including mid-handshake.
- Priority order: (low_prio+1) mod 8 is highest, wrapping down to low_prio as lowest.
- cand = highest-priority set bit of irr.
- cand is eligible only if isr==0 or cand outranks the highest-priority set ISR bit (fully nested).
- Edges: rise = inta & ~inta_d; fall = ~inta & inta_d, using inta_d after optional sync.
- FSM states: IDLE, REQ, ACK1, ACK2.
  - IDLE: eligible cand -> REQ; int_req=1 registered, so INT appears 1 cycle after irr.
  - REQ: int_req held even if irr drops.
    - On rise: re-evaluate cand.
    - If eligible: ack_id<=cand, isr[cand]<=1, clr_irr[cand] pulsed 1 cycle.
    - Else spurious: ack_id<=7, no ISR/clr_irr change.
    - int_req<=0 -> ACK1.
  - ACK1: ignore fall; on next rise: data_out<={vector_base, ack_id}, data_valid=1 for 1 cycle -> ACK2.
  - ACK2: on fall -> IDLE.
    - If auto_eoi and not spurious: isr[ack_id]<=0.
    - If additionally eoi_rotate is high that cycle: low_prio<=ack_id.
- A rise in IDLE is ignored; no data_valid is produced.
- EOI (any state, 1 cycle):
  - Non-specific clears the highest-priority set ISR bit.
  - Specific clears isr[eoi_level].
  - If eoi_rotate and a bit was actually cleared: low_prio<=cleared level.
  - Clearing an already-zero bit is a no-op, including no rotation.
- Simultaneous EOI and first-INTA set: EOI evaluates on pre-update isr. If both target the same bit, set wins.
- An EOI that makes a pending request eligible causes IDLE->REQ the following cycle.

Optional Feature:
POLL_CMD_EN:
- When defined, adds input poll (one-cycle strobe), accepted in IDLE or REQ.
- Next cycle: data_out<={eligible?1:0, 4'b0, cand}, data_valid=1.
- If eligible: isr[cand] and clr_irr[cand] are set as on a first INTA.
- int_req<=0; state -> IDLE.
- When undefined: port absent, no poll logic.

Test Plan:
- Reset, irr=8'h08, vector_base=5'h10, two INTA pulses -> int_req=1 at cycle+1; clr_irr=8'h08; isr=8'h08; data_out=8'h83 with data_valid for 1 cycle; int_req=0.
- isr=8'h08, irr=8'h21 -> IR0 acknowledged (isr=8'h09); IR5 not requested until non-specific EOI clears bit0 and then bit3.
- irr=8'h04 raised, dropped before first INTA -> spurious: data_out={base,3'd7}, isr unchanged, clr_irr=0.
- auto_eoi=1, eoi_rotate=1, ack IR2 -> isr returns 0 at second-INTA fall; low_prio=2; next irr=8'h09 selects IR3 before IR0.
- Specific EOI level 5 with isr=8'h24 -> isr=8'h04; non-specific EOI with isr=0 -> no change, low_prio unchanged.
- Assert reset during ACK1 -> all outputs 0 immediately; new request restarts from IDLE.

Source files
------------

// File: rtl/intr_ack_sequencer.sv
// ============================================================================
// intr_ack_sequencer : 8259-style INTA sequencer with ISR, vector and EOI/rotation
// Optional poll command enabled by defining POLL_CMD_EN.   Revision: 1.0
// ============================================================================
`default_nettype none

module intr_ack_sequencer #(
  parameter logic [2:0] LOW_PRIO_RST = 3'd7,
  parameter int         INTA_SYNC    = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] irr,
  input  logic       inta,
  input  logic [4:0] vector_base,
  input  logic       auto_eoi,
  input  logic       eoi,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       eoi_rotate,
`ifdef POLL_CMD_EN
  input  logic       poll,
`endif
  output logic       int_req,
  output logic [7:0] isr,
  output logic [7:0] clr_irr,
  output logic [7:0] data_out,
  output logic       data_valid
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_ACK1 = 2'd2;
  localparam logic [1:0] S_ACK2 = 2'd3;

  // Returns {found, index} of the highest-priority set bit; lp is the lowest level.
  function automatic logic [3:0] pick(input logic [7:0] v, input logic [2:0] lp);
    logic [2:0] idx;
    pick = 4'b0;
    for (int i = 7; i >= 0; i--) begin
      idx = lp + 3'(i + 1);
      if (v[idx]) pick = {1'b1, idx};
    end
  endfunction

  function automatic logic [2:0] rank(input logic [2:0] idx, input logic [2:0] lp);
    rank = idx - lp - 3'd1;
  endfunction

  logic [1:0] state, state_next;
  logic [2:0] low_prio, ack_id;
  logic       spurious, inta_s, inta_d, rise, fall;
  logic       cand_found, isr_found, eligible;
  logic [2:0] cand, isr_top;
  logic       poll_go, take, set_isr, eoi_hit, auto_clr, load_data;
  logic [2:0] eoi_sel;
  logic [7:0] set_mask, clr_mask, data_next;

  generate
    if (INTA_SYNC != 0) begin : g_inta_sync
      logic [1:0] sync_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= 2'b00;
        else       sync_q <= {sync_q[0], inta};
      end
      assign inta_s = sync_q[1];
    end else begin : g_inta_direct
      assign inta_s = inta;
    end
  endgenerate

  assign rise = inta_s & ~inta_d;
  assign fall = ~inta_s & inta_d;

  assign {cand_found, cand}   = pick(irr, low_prio);
  assign {isr_found, isr_top} = pick(isr, low_prio);
  assign eligible = cand_found && (!isr_found || (rank(cand, low_prio) < rank(isr_top, low_prio)));

`ifdef POLL_CMD_EN
  assign poll_go = poll && ((state == S_IDLE) || (state == S_REQ));
`else
  assign poll_go = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (eligible) state_next = S_REQ;
      S_REQ:   if (rise)     state_next = S_ACK1;
      S_ACK1:  if (rise)     state_next = S_ACK2;
      S_ACK2:  if (fall)     state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (poll_go) state_next = S_IDLE;
  end

  // EOI sees the pre-update ISR; set is OR-ed in last so it wins on a collision.
  always_comb begin
    take      = (state == S_REQ) && rise && !poll_go;
    set_isr   = (take || poll_go) && eligible;
    set_mask  = set_isr ? (8'd1 << cand) : 8'd0;
    eoi_sel   = eoi_specific ? eoi_level : isr_top;
    eoi_hit   = eoi && (eoi_specific ? isr[eoi_level] : isr_found);
    auto_clr  = (state == S_ACK2) && fall && auto_eoi && !spurious;
    clr_mask  = (eoi_hit ? (8'd1 << eoi_sel) : 8'd0) | (auto_clr ? (8'd1 << ack_id) : 8'd0);
    load_data = ((state == S_ACK1) && rise) || poll_go;
    data_next = poll_go ? {eligible, 4'b0000, cand} : {vector_base, ack_id};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inta_d     <= 1'b0;
      int_req    <= 1'b0;
      isr        <= 8'd0;
      clr_irr    <= 8'd0;
      data_out   <= 8'd0;
      data_valid <= 1'b0;
      low_prio   <= LOW_PRIO_RST;
      ack_id     <= 3'd7;
      spurious   <= 1'b0;
    end else begin
      inta_d     <= inta_s;
      int_req    <= (state_next == S_REQ);
      isr        <= (isr & ~clr_mask) | set_mask;
      clr_irr    <= set_mask;
      data_valid <= load_data;
      if (load_data) data_out <= data_next;
      if (take) begin
        ack_id   <= eligible ? cand : 3'd7;
        spurious <= !eligible;
      end
      if (eoi_hit && eoi_rotate)       low_prio <= eoi_sel;
      else if (auto_clr && eoi_rotate) low_prio <= ack_id;
    end
  end

endmodule

`default_nettype wire
